// File: rtl/wb_ram_arbiter_if.sv
// Wishbone bundle for the two-master RAM arbiter: both master ports plus the RAM slave port.
// The slave modport is the arbiter's view; the master modport is the masters + RAM side.
interface wb_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              m0_wb_CYC_I;
  logic              m0_wb_STB_I;
  logic              m0_wb_WE_I;
  logic [3:0]        m0_wb_SEL_I;
  logic [ADDR_W-1:0] m0_wb_ADR_I;
  logic [DATA_W-1:0] m0_wb_DAT_I;
  logic              m0_wb_ACK_O;
  logic [DATA_W-1:0] m0_wb_DAT_O;

  logic              m1_wb_CYC_I;
  logic              m1_wb_STB_I;
  logic              m1_wb_WE_I;
  logic [3:0]        m1_wb_SEL_I;
  logic [ADDR_W-1:0] m1_wb_ADR_I;
  logic [DATA_W-1:0] m1_wb_DAT_I;
  logic              m1_wb_ACK_O;
  logic [DATA_W-1:0] m1_wb_DAT_O;

  logic              s_wb_CYC_O;
  logic              s_wb_STB_O;
  logic              s_wb_WE_O;
  logic [3:0]        s_wb_SEL_O;
  logic [ADDR_W-1:0] s_wb_ADR_O;
  logic [DATA_W-1:0] s_wb_DAT_O;
  logic [DATA_W-1:0] s_wb_DAT_I;
  logic              s_wb_ACK_I;

  modport slave (
    input  m0_wb_CYC_I, m0_wb_STB_I, m0_wb_WE_I, m0_wb_SEL_I, m0_wb_ADR_I, m0_wb_DAT_I,
    output m0_wb_ACK_O, m0_wb_DAT_O,
    input  m1_wb_CYC_I, m1_wb_STB_I, m1_wb_WE_I, m1_wb_SEL_I, m1_wb_ADR_I, m1_wb_DAT_I,
    output m1_wb_ACK_O, m1_wb_DAT_O,
    output s_wb_CYC_O, s_wb_STB_O, s_wb_WE_O, s_wb_SEL_O, s_wb_ADR_O, s_wb_DAT_O,
    input  s_wb_DAT_I, s_wb_ACK_I
  );

  modport master (
    output m0_wb_CYC_I, m0_wb_STB_I, m0_wb_WE_I, m0_wb_SEL_I, m0_wb_ADR_I, m0_wb_DAT_I,
    input  m0_wb_ACK_O, m0_wb_DAT_O,
    output m1_wb_CYC_I, m1_wb_STB_I, m1_wb_WE_I, m1_wb_SEL_I, m1_wb_ADR_I, m1_wb_DAT_I,
    input  m1_wb_ACK_O, m1_wb_DAT_O,
    input  s_wb_CYC_O, s_wb_STB_O, s_wb_WE_O, s_wb_SEL_O, s_wb_ADR_O, s_wb_DAT_O,
    output s_wb_DAT_I, s_wb_ACK_I
  );
endinterface

// File: rtl/wb_ram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single RAM slave port, with a
// per-grant hold watchdog that raises a sticky flag when one master keeps the bus too long.
module wb_ram_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 64,
  parameter int unsigned HOLD_W   = 7
) (
  input  logic                   clk,
  input  logic                   nRST,
  wb_ram_arbiter_if.slave        bus,
  output logic [1:0]             grant,
  output logic                   hold_timeout,
  input  logic                   timeout_clr
);

  typedef enum logic [1:0] {StIdle, StOwnM0, StOwnM1} state_e;

  state_e            state_q;
  logic [1:0]        grant_q;
  logic              last_owner_q;  // 0 = m0 owned last, 1 = m1 owned last
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              hold_timeout_q;

  logic owned;
  logic hold_hit;
  logic hold_sat;

  assign owned    = (state_q == StOwnM0) || (state_q == StOwnM1);
  assign hold_sat = (hold_cnt_q == HOLD_W'(MAX_HOLD));
  // Fires only on the cycle the counter steps onto MAX_HOLD, so a clear sticks afterwards.
  assign hold_hit = owned && (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q        <= StIdle;
      grant_q        <= 2'b00;
      last_owner_q   <= 1'b1;
      hold_cnt_q     <= '0;
      hold_timeout_q <= 1'b0;
    end else begin
      if (hold_hit) begin
        hold_timeout_q <= 1'b1;
      end else if (timeout_clr) begin
        hold_timeout_q <= 1'b0;
      end

      if (owned && !hold_sat) begin
        hold_cnt_q <= hold_cnt_q + 1'b1;
      end

      case (state_q)
        StIdle: begin
          hold_cnt_q <= '0;
          if (bus.m0_wb_CYC_I && (!bus.m1_wb_CYC_I || last_owner_q)) begin
            state_q <= StOwnM0;
            grant_q <= 2'b01;
          end else if (bus.m1_wb_CYC_I) begin
            state_q <= StOwnM1;
            grant_q <= 2'b10;
          end
        end
        StOwnM0: begin
          if (!bus.m0_wb_CYC_I) begin
            state_q      <= StIdle;
            grant_q      <= 2'b00;
            last_owner_q <= 1'b0;
          end
        end
        StOwnM1: begin
          if (!bus.m1_wb_CYC_I) begin
            state_q      <= StIdle;
            grant_q      <= 2'b00;
            last_owner_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  assign grant        = grant_q;
  assign hold_timeout = hold_timeout_q;

  // Slave port and ack steering are a pure function of the registered owner.
  always_comb begin
    bus.s_wb_CYC_O  = 1'b0;
    bus.s_wb_STB_O  = 1'b0;
    bus.s_wb_WE_O   = 1'b0;
    bus.s_wb_SEL_O  = 4'h0;
    bus.s_wb_ADR_O  = {ADDR_W{1'b0}};
    bus.s_wb_DAT_O  = {DATA_W{1'b0}};
    bus.m0_wb_ACK_O = 1'b0;
    bus.m1_wb_ACK_O = 1'b0;
    case (state_q)
      StOwnM0: begin
        bus.s_wb_CYC_O  = bus.m0_wb_CYC_I;
        bus.s_wb_STB_O  = bus.m0_wb_STB_I;
        bus.s_wb_WE_O   = bus.m0_wb_WE_I;
        bus.s_wb_SEL_O  = bus.m0_wb_SEL_I;
        bus.s_wb_ADR_O  = bus.m0_wb_ADR_I;
        bus.s_wb_DAT_O  = bus.m0_wb_DAT_I;
        bus.m0_wb_ACK_O = bus.s_wb_ACK_I;
      end
      StOwnM1: begin
        bus.s_wb_CYC_O  = bus.m1_wb_CYC_I;
        bus.s_wb_STB_O  = bus.m1_wb_STB_I;
        bus.s_wb_WE_O   = bus.m1_wb_WE_I;
        bus.s_wb_SEL_O  = bus.m1_wb_SEL_I;
        bus.s_wb_ADR_O  = bus.m1_wb_ADR_I;
        bus.s_wb_DAT_O  = bus.m1_wb_DAT_I;
        bus.m1_wb_ACK_O = bus.s_wb_ACK_I;
      end
      default: ;
    endcase
  end

  assign bus.m0_wb_DAT_O = bus.s_wb_DAT_I;
  assign bus.m1_wb_DAT_O = bus.s_wb_DAT_I;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Self-checking bench for wb_ram_arbiter: arbitration vector table, a small RAM model with a
// read-data scoreboard, and hand-written sequences for latency, bursts, watchdog and reset.
module tb_wb_ram_arbiter;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXH = 8;
  localparam int unsigned HW   = 4;

  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic       timeout_clr = 1'b0;
  logic [1:0] grant;
  logic       hold_timeout;

  wb_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  wb_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MAXH), .HOLD_W(HW)) dut (
    .clk          (clk),
    .nRST         (nRST),
    .bus          (bus),
    .grant        (grant),
    .hold_timeout (hold_timeout),
    .timeout_clr  (timeout_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM model: one wait state, ACK for one cycle per strobe.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  logic          ram_ack_q;
  int unsigned   ram_w_q;
  logic          stray_ack = 1'b0;
  logic [7:0]    idx;
  assign idx            = bus.s_wb_ADR_O[9:2];
  assign bus.s_wb_ACK_I = ram_ack_q;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ram_ack_q      <= 1'b0;
      ram_w_q        <= 0;
      bus.s_wb_DAT_I <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else begin
      ram_ack_q <= stray_ack;
      if (bus.s_wb_CYC_O && bus.s_wb_STB_O && !ram_ack_q) begin
        if (ram_w_q == 1) begin
          ram_ack_q <= 1'b1;
          ram_w_q   <= 0;
          if (bus.s_wb_WE_O) mem[idx] <= bus.s_wb_DAT_O;
          else bus.s_wb_DAT_I <= mem[idx];
        end else begin
          ram_w_q <= ram_w_q + 1;
        end
      end else begin
        ram_w_q <= 0;
      end
    end
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int bad_route = 0;
  always @(negedge clk) begin
    if ((bus.m0_wb_ACK_O && grant != 2'b01) || (bus.m1_wb_ACK_O && grant != 2'b10))
      bad_route <= bad_route + 1;
  end

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      bus.m0_wb_CYC_I = cyc; bus.m0_wb_STB_I = stb; bus.m0_wb_WE_I = we;
      bus.m0_wb_SEL_I = cyc ? 4'hF : 4'h0; bus.m0_wb_ADR_I = adr; bus.m0_wb_DAT_I = dat;
    end else begin
      bus.m1_wb_CYC_I = cyc; bus.m1_wb_STB_I = stb; bus.m1_wb_WE_I = we;
      bus.m1_wb_SEL_I = cyc ? 4'hF : 4'h0; bus.m1_wb_ADR_I = adr; bus.m1_wb_DAT_I = dat;
    end
  endtask

  function automatic logic ack_of(input int m);
    return (m == 0) ? bus.m0_wb_ACK_O : bus.m1_wb_ACK_O;
  endfunction

  function automatic logic [31:0] dat_of(input int m);
    return (m == 0) ? bus.m0_wb_DAT_O : bus.m1_wb_DAT_O;
  endfunction

  task automatic wait_ack(input int m, input string tag, output bit got);
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ack_of(m)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s: no ack after 100 cycles, required ack", tag);
    end
  endtask

  task automatic check_ack(input int m, input bit we, input string tag);
    logic [31:0] e;
    chk($sformatf("%s_other_ack", tag), 32'(ack_of(1 - m)), 32'h0);
    if (!we) begin
      e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      chk($sformatf("%s_rdata", tag), dat_of(m), e);
    end
  endtask

  // Drives n single-word transfers inside one CYC, scoreboarding reads at issue time.
  task automatic xfer(input int m, input bit we, input logic [31:0] adr, input int n);
    logic [31:0] a;
    logic [31:0] d;
    bit          got;
    for (int w = 0; w < n; w++) begin
      a = adr + 32'(w * 4);
      d = 32'h5A00_0000 ^ a;
      set_m(m, 1'b1, 1'b1, we, a, d);
      if (we) ref_mem[a[9:2]] = d;
      else if (m == 0) exp_q0.push_back(ref_mem[a[9:2]]);
      else exp_q1.push_back(ref_mem[a[9:2]]);
      wait_ack(m, $sformatf("m%0d_w%0d", m, w), got);
      if (got) check_ack(m, we, $sformatf("m%0d_w%0d", m, w));
    end
    set_m(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRST = 1'b0;
    ref_reset();
    @(negedge clk);
    nRST = 1'b1;
  endtask

  typedef struct packed {
    logic        c0;
    logic        c1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [1:0]  g;
    logic [31:0] sadr;
  } vec_t;

  vec_t        tbl [9];
  logic [1:0]  glog[$];
  int          m1_drop_cyc = 0;
  bit          got;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 32'h0A00, 32'h0B00, 2'b00, 32'h0000};
    tbl[1] = '{1'b1, 1'b1, 32'h0A04, 32'h0B04, 2'b01, 32'h0A04};
    tbl[2] = '{1'b1, 1'b1, 32'h0A08, 32'h0B08, 2'b10, 32'h0B08};
    tbl[3] = '{1'b0, 1'b1, 32'h0A0C, 32'h0B0C, 2'b10, 32'h0B0C};
    tbl[4] = '{1'b1, 1'b0, 32'h0A10, 32'h0B10, 2'b01, 32'h0A10};
    tbl[5] = '{1'b1, 1'b1, 32'h0A14, 32'h0B14, 2'b10, 32'h0B14};
    tbl[6] = '{1'b1, 1'b0, 32'h0A18, 32'h0B18, 2'b01, 32'h0A18};
    tbl[7] = '{1'b0, 1'b1, 32'h0A1C, 32'h0B1C, 2'b10, 32'h0B1C};
    tbl[8] = '{1'b1, 1'b1, 32'h0A20, 32'h0B20, 2'b01, 32'h0A20};

    ref_reset();
    // Busy-looking inputs during reset: the slave port must still read all zero.
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h1234, 32'hDEAD_BEEF);
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h5678, 32'hCAFE_F00D);
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_s_cyc", 32'(bus.s_wb_CYC_O), 32'h0);
    chk("rst_s_stb", 32'(bus.s_wb_STB_O), 32'h0);
    chk("rst_s_we", 32'(bus.s_wb_WE_O), 32'h0);
    chk("rst_s_sel", 32'(bus.s_wb_SEL_O), 32'h0);
    chk("rst_s_adr", bus.s_wb_ADR_O, 32'h0);
    chk("rst_s_dat", bus.s_wb_DAT_O, 32'h0);
    chk("rst_acks", 32'({bus.m0_wb_ACK_O, bus.m1_wb_ACK_O}), 32'h0);
    chk("rst_timeout", 32'(hold_timeout), 32'h0);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nRST = 1'b1;

    // Stray ACK while idle is dropped.
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    chk("stray_ram_ack", 32'(bus.s_wb_ACK_I), 32'h1);
    chk("stray_m_acks", 32'({bus.m0_wb_ACK_O, bus.m1_wb_ACK_O}), 32'h0);
    @(negedge clk);
    chk("stray_grant", 32'(grant), 32'h0);

    // Arbitration table: one owned cycle then the mandatory idle cycle.
    for (int i = 0; i < 9; i++) begin
      set_m(0, tbl[i].c0, tbl[i].c0, 1'b0, tbl[i].a0, 32'h0);
      set_m(1, tbl[i].c1, tbl[i].c1, 1'b0, tbl[i].a1, 32'h0);
      @(negedge clk);
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("vec%0d_s_cyc", i), 32'(bus.s_wb_CYC_O), 32'(|tbl[i].g));
      chk($sformatf("vec%0d_s_adr", i), bus.s_wb_ADR_O, tbl[i].sadr);
      set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk($sformatf("vec%0d_idle", i), 32'(grant), 32'h0);
    end

    // m1 read alone.
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    exp_q1.push_back(ref_mem[64]);
    @(negedge clk);
    chk("t1_grant", 32'(grant), 32'h2);
    chk("t1_s_adr", bus.s_wb_ADR_O, 32'h100);
    chk("t1_s_stb", 32'(bus.s_wb_STB_O), 32'h1);
    wait_ack(1, "t1_ack", got);
    if (got) check_ack(1, 1'b0, "t1");
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Tie right after reset goes to m0; m1 waits out the idle cycle.
    do_reset();
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t2_first", 32'(grant), 32'h1);
    repeat (4) @(negedge clk);
    chk("t2_no_preempt", 32'(grant), 32'h1);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t2_idle", 32'(grant), 32'h0);
    @(negedge clk);
    chk("t2_m1", 32'(grant), 32'h2);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Both masters re-request continuously, one word per grant.
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          xfer(0, 1'b1, 32'h200 + 32'(k * 4), 1);
          @(negedge clk);
        end
      end
      begin
        for (int k = 0; k < 3; k++) begin
          xfer(1, 1'b0, 32'h200 + 32'(k * 4) + 32'h100, 1);
          @(negedge clk);
        end
      end
      begin
        for (int k = 0; k < 60; k++) begin
          @(negedge clk);
          glog.push_back(grant);
        end
      end
    join
    begin
      int         nz_runs = 0;
      int         bad_gap = 0;
      int         same    = 0;
      int         zlen    = 0;
      logic [1:0] prev    = 2'b00;
      logic [1:0] last_nz = 2'b00;
      foreach (glog[i]) begin
        if (glog[i] == 2'b00) begin
          zlen++;
        end else begin
          if (glog[i] != prev) begin
            if (nz_runs > 0) begin
              if (zlen != 1) bad_gap++;
              if (glog[i] == last_nz) same++;
            end
            nz_runs++;
            last_nz = glog[i];
          end
          zlen = 0;
        end
        prev = glog[i];
      end
      chk("t3_grant_runs", 32'(nz_runs), 32'd6);
      chk("t3_idle_gaps", 32'(bad_gap), 32'd0);
      chk("t3_alternate", 32'(same), 32'd0);
    end

    // m1 burst of 10 reads; m0 requests mid-burst and must wait.
    fork
      begin
        xfer(1, 1'b0, 32'h000, 10);
        m1_drop_cyc = cyc_cnt;
      end
      begin
        repeat (3) @(negedge clk);
        xfer(0, 1'b1, 32'h3C0, 1);
      end
      begin
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
          @(negedge clk);
          if (grant == 2'b01) begin
            got = 1'b1;
            break;
          end
        end
        if (got) chk("t4_m0_regrant_delay", 32'(cyc_cnt - m1_drop_cyc), 32'd2);
        else chk("t4_m0_granted", 32'(grant), 32'h1);
      end
    join
    chk("t4_queue_drained", 32'(exp_q1.size()), 32'd0);
    chk("t4_long_hold_flag", 32'(hold_timeout), 32'h1);
    @(negedge clk);

    // Watchdog with MAX_HOLD = 8.
    timeout_clr = 1'b1;
    @(negedge clk);
    timeout_clr = 1'b0;
    chk("t5_clear", 32'(hold_timeout), 32'h0);
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      chk($sformatf("t5_hold%0d", i), 32'(hold_timeout), 32'(i >= 8));
    end
    chk("t5_not_revoked", 32'(grant), 32'h1);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t5_sticky", 32'(hold_timeout), 32'h1);
    timeout_clr = 1'b1;
    @(negedge clk);
    timeout_clr = 1'b0;
    chk("t5_cleared", 32'(hold_timeout), 32'h0);
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    timeout_clr = 1'b1;
    repeat (7) @(negedge clk);
    chk("t5_co_before", 32'(hold_timeout), 32'h0);
    @(negedge clk);
    chk("t5_set_wins", 32'(hold_timeout), 32'h1);
    timeout_clr = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t5_co_kept", 32'(hold_timeout), 32'h1);

    // Asynchronous reset in the middle of an m1 burst.
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h040, 32'h0);
    @(negedge clk);
    chk("t6_owned", 32'(grant), 32'h2);
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h080, 32'h0);
    #2;
    nRST = 1'b0;
    #1;
    chk("t6_s_cyc", 32'(bus.s_wb_CYC_O), 32'h0);
    chk("t6_s_stb", 32'(bus.s_wb_STB_O), 32'h0);
    chk("t6_grant", 32'(grant), 32'h0);
    chk("t6_timeout", 32'(hold_timeout), 32'h0);
    @(negedge clk);
    ref_reset();
    nRST = 1'b1;
    @(negedge clk);
    chk("t6_m0_first", 32'(grant), 32'h1);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);

    chk("ack_routing", 32'(bad_route), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
